// File: rtl/fir_sym_pkg.sv
// Shared constants and helpers for the symmetric FIR.
// The derived constants here describe the default build only.
package fir_sym_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_TAPS   = 32;
  localparam int DEF_FRAC_W = 15;

  localparam int HALF  = DEF_TAPS / 2;
  localparam int LVL   = clog2(HALF);
  localparam int ACC_W = DEF_DATA_W + DEF_COEF_W + 1 + LVL;
  localparam int LAT   = 2 + LVL;

endpackage

// File: rtl/fir_sym_param_tree.sv
// Pipelined binary adder tree. There is one registered level per halving,
// each level one bit wider, and a valid bit travels alongside the data.
module fir_add_tree
  import fir_sym_pkg::*;
#(
  parameter int IN_W = 33,
  parameter int N    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_vld,
  input  logic [N-1:0][IN_W-1:0]        in_data,
  output logic                          out_vld,
  output logic [IN_W+clog2(N)-1:0]      out_data
);
  localparam int L = clog2(N);

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int CNT = N >> (l + 1);
    localparam int OW  = IN_W + l + 1;
    logic [2*CNT-1:0][OW-2:0] src;
    logic                     src_vld;
    logic [CNT-1:0][OW-1:0]   sum;
    logic                     vld;

    if (l == 0) begin : g_in
      assign src     = in_data;
      assign src_vld = in_vld;
    end else begin : g_in
      assign src     = g_lvl[l-1].sum;
      assign src_vld = g_lvl[l-1].vld;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum <= '0;
        vld <= 1'b0;
      end else begin
        vld <= src_vld & ~clr;
        for (int j = 0; j < CNT; j++)
          sum[j] <= {src[2*j][OW-2], src[2*j]} + {src[2*j+1][OW-2], src[2*j+1]};
      end
    end
  end

  assign out_data = g_lvl[L-1].sum;
  assign out_vld  = g_lvl[L-1].vld;

endmodule

// File: rtl/fir_sym_param.sv
// Symmetric-coefficient FIR with loadable coefficients, warm-up-gated valid and flush.
// Define FIR_SAT_EN to clip the rounded output; otherwise the output wraps.
module fir_sym_param
  import fir_sym_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_valid,
  input  logic [DATA_W-1:0]            data,
  input  logic                         clr,
  input  logic                         coef_we,
  input  logic [clog2(TAPS/2)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]            coef_wdata,
  output logic                         fir_valid,
  output logic [DATA_W-1:0]            fir_d,
  output logic                         sat_flag
);
  localparam int NH    = TAPS / 2;
  localparam int NL    = clog2(NH);
  localparam int CNT_W = clog2(TAPS);
  localparam int PRE_W = DATA_W + 1;
  localparam int PRD_W = PRE_W + COEF_W;
  localparam int SUM_W = PRD_W + NL;
  localparam logic signed [SUM_W:0] RND_K = {{SUM_W{1'b0}}, 1'b1} << (FRAC_W - 1);

  logic [NH-1:0][COEF_W-1:0]   coef_q;
  logic [TAPS-2:0][DATA_W-1:0] dly;
  logic [TAPS-1:0][DATA_W-1:0] win;
  logic [CNT_W-1:0]            cnt;
  logic                        warm;
  logic [NH-1:0][PRE_W-1:0]    pre_q;
  logic [NH-1:0][PRD_W-1:0]    prd_q;
  logic [1:0]                  vld_pipe;
  logic [SUM_W-1:0]            acc;
  logic                        acc_vld;
  logic signed [SUM_W:0]       rnd, shf;
  logic [DATA_W-1:0]           res;
  logic                        sat;

  // win[0] is the incoming sample, win[j] is x[n-j]
  assign win  = {dly, data};
  assign warm = (cnt == CNT_W'(TAPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          coef_q <= '0;
    else if (coef_we) coef_q[coef_addr] <= coef_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly <= '0;
      cnt <= '0;
    end else if (clr) begin
      dly <= '0;
      cnt <= '0;
    end else if (data_valid) begin
      dly <= win[TAPS-2:0];
      if (!warm) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      prd_q    <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= data_valid & warm & ~clr;
      vld_pipe[1] <= vld_pipe[0] & ~clr;
      for (int i = 0; i < NH; i++) begin
        pre_q[i] <= PRE_W'($signed(win[i])) + PRE_W'($signed(win[TAPS-1-i]));
        prd_q[i] <= PRD_W'($signed(pre_q[i])) * PRD_W'($signed(coef_q[i]));
      end
    end
  end

  fir_add_tree #(.IN_W(PRD_W), .N(NH)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_vld   (vld_pipe[1]),
    .in_data  (prd_q),
    .out_vld  (acc_vld),
    .out_data (acc)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [SUM_W:0] MAX_K = {{(SUM_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] MIN_K = {{(SUM_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    rnd = $signed({acc[SUM_W-1], acc}) + RND_K;
    shf = rnd >>> FRAC_W;
    res = DATA_W'(shf);
    sat = 1'b0;
`ifdef FIR_SAT_EN
    if (shf > MAX_K) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
      sat = 1'b1;
    end else if (shf < MIN_K) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
      sat = 1'b1;
    end
`endif
  end

  // The output register ignores clr: a result already at the last stage still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_valid <= 1'b0;
      fir_d     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      fir_valid <= acc_vld;
      if (acc_vld) begin
        fir_d    <= res;
        sat_flag <= sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_sym_param.sv
// Directed bench for fir_sym_param at default parameters: a vector table plus
// hand-written impulse, gap, flush and reset sequences.
module tb_fir_sym_param;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic        clr = 1'b0;
  logic        coef_we = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] coef_wdata = '0;
  logic [3:0]  coef_addr = '0;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        sat_flag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int k;

  typedef struct { int c; int d; int s; } cap_t;
  typedef struct { int c0; int crest; int warm; int probe; int exp_d; int exp_s; } vec_t;
  cap_t caps[$];
  int   acc_cyc[$];
  vec_t vt[8];

  fir_sym_param dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .clr        (clr),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst && fir_valid) caps.push_back('{cyc, int'($signed(fir_d)), int'(sat_flag)});

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; data_valid = 1'b0; clr = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    caps.delete();
    acc_cyc.delete();
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 4'(a); coef_wdata = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic step(input logic v, input int x);
    data_valid = v; data = 16'(x);
    if (v) acc_cyc.push_back(cyc + 1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic feed_impulse(input logic gap);
    for (int n = 0; n < 70; n++) begin
      step(1'b1, (n == 31) ? 1000 : 0);
      if (gap) step(1'b0, 16'h5A5A);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_impulse(input string nm, input int base);
    cap_t r[$];
    foreach (caps[i]) if (caps[i].c > base) r.push_back(caps[i]);
    chk({nm, "_cnt"}, r.size(), 39);
    for (int j = 0; j < 39 && j < r.size(); j++) begin
      chk($sformatf("%s_d%0d", nm, j), r[j].d, (j == 0 || j == 31) ? 500 : 0);
      chk($sformatf("%s_lat%0d", nm, j), r[j].c, acc_cyc[31+j] + LAT);
    end
  endtask

  initial begin
    //        c0      crest   warm    probe   exp_d   exp_s
    vt[0] = '{1,      0,      0,      16384,  1,      0};
    vt[1] = '{1,      0,      0,      16383,  0,      0};
    vt[2] = '{1,      0,      0,      -16385, -1,     0};
    vt[5] = '{16384,  0,      1000,   1000,   1000,   0};
    vt[6] = '{2048,   2048,   100,    100,    200,    0};
`ifdef FIR_SAT_EN
    vt[3] = '{32767,  32767,  32767,  32767,  32767,  1};
    vt[4] = '{32767,  32767,  -32768, -32768, -32768, 1};
    vt[7] = '{-32768, -32768, 32767,  32767,  -32768, 1};
`else
    vt[3] = '{32767,  32767,  32767,  32767,  -64,    0};
    vt[4] = '{32767,  32767,  -32768, -32768, 32,     0};
    vt[7] = '{-32768, -32768, 32767,  32767,  32,     0};
`endif

    do_reset();
    chk("rst_vld", int'(fir_valid), 0);
    chk("rst_d", int'($signed(fir_d)), 0);
    chk("rst_sat", int'(sat_flag), 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int a = 0; a < 16; a++) wcoef(a, (a == 0) ? vt[v].c0 : vt[v].crest);
      caps.delete();
      repeat (32) step(1'b1, vt[v].warm);
      step(1'b1, vt[v].probe);
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d_cnt", v), caps.size(), 2);
      if (caps.size() >= 2) begin
        chk($sformatf("vec%0d_d", v), caps[1].d, vt[v].exp_d);
        chk($sformatf("vec%0d_sat", v), caps[1].s, vt[v].exp_s);
      end
    end

    // impulse, dense
    do_reset();
    wcoef(0, 16384);
    feed_impulse(1'b0);
    check_impulse("imp", 0);

    // impulse with valid toggling every cycle
    do_reset();
    wcoef(0, 16384);
    feed_impulse(1'b1);
    check_impulse("gap", 0);

    // flush mid-stream, with a colliding sample and coefficient write
    do_reset();
    wcoef(0, 8192);
    repeat (40) step(1'b1, 2000);
    clr = 1'b1; data_valid = 1'b1; data = 16'd3000;
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'd16384;
    @(negedge clk);
    clr = 1'b0; data_valid = 1'b0; coef_we = 1'b0;
    k = cyc;
    acc_cyc.delete();
    feed_impulse(1'b0);
    check_impulse("clr", k);

    // asynchronous reset mid-stream
    do_reset();
    wcoef(0, 16384);
    repeat (40) step(1'b1, 1000);
    chk("prerst_vld", int'(fir_valid), 1);
    chk("prerst_d", int'($signed(fir_d)), 1000);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", int'(fir_valid), 0);
    chk("arst_d", int'($signed(fir_d)), 0);
    chk("arst_sat", int'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    caps.delete();
    acc_cyc.delete();
    repeat (40) step(1'b1, 1000);
    repeat (10) @(negedge clk);
    chk("post_rst_cnt", caps.size(), 9);
    for (int j = 0; j < 9 && j < caps.size(); j++) begin
      chk($sformatf("post_rst_d%0d", j), caps[j].d, 0);
      chk($sformatf("post_rst_lat%0d", j), caps[j].c, acc_cyc[31+j] + LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sym_param.md
# fir_sym_param

Parametrised symmetric-coefficient FIR filter: next generation of the fixed 32-tap filter in the signal path. Sample width, coefficient width, tap count and fractional scaling are parameters. Coefficients are runtime-loadable. The block adds warm-up-aware output valid, gap-tolerant streaming, synchronous flush and round/saturate output. It sits between the sample source (`data_valid`/`data`) and downstream consumers of `fir_valid`/`fir_d`.

## Interface
Parameters:
- `DATA_W`, default 16: signed sample and output width.
- `COEF_W`, default 16: signed coefficient width.
- `TAPS`, default 32: tap count. Must be even, and `TAPS/2` a power of 2, ≥ 2.
- `FRAC_W`, default 15: coefficient fractional bits; the result is scaled by 2^-FRAC_W.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `data_valid`, in, 1: `data` is a new sample this cycle.
- `data`, in, `DATA_W`: signed sample.
- `clr`, in, 1: synchronous flush.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, log2(TAPS/2): coefficient index i.
- `coef_wdata`, in, `COEF_W`: signed coefficient value.
- `fir_valid`, out, 1: `fir_d` holds a new result this cycle (single-cycle pulse per result).
- `fir_d`, out, `DATA_W`: signed filtered sample.
- `sat_flag`, out, 1: the result qualified by `fir_valid` was clipped.

## Operation
- Filter: y[n] = Σ c[i]·(x[n−i] + x[n−(TAPS−1−i)]), for i = 0..TAPS/2−1.
- Delay line holds TAPS−1 samples and advances only on `data_valid`. Pipeline stages advance every cycle; a valid bit travels with each sample.
- Stages:
  1. Pre-add: `data` paired with the delay line, DATA_W+1 bits.
  2. Multiply: DATA_W+1+COEF_W bits.
  3. Adder tree: log2(TAPS/2) registered levels, +1 bit per level. ACC_W = DATA_W+COEF_W+1+log2(TAPS/2).
  4. Output stage: add 2^(FRAC_W−1), arithmetic shift right by FRAC_W, then reduce to DATA_W.
- Warm-up: a sample counter (saturating at TAPS−1) counts accepted samples since reset or `clr`. The result for sample n is marked valid only if n ≥ TAPS−1, i.e. from the TAPS-th sample on.
- Coefficient bank: TAPS/2 registers, all reset to 0. A write on edge k is used by every multiply-stage operation on edges after k. Coefficients are not affected by `clr`.
- `clr`: zeroes the delay line, warm-up counter and all in-flight valid bits. Coefficients are kept.
  - `clr` and `data_valid` in the same cycle: `clr` wins and the sample is dropped.
  - `clr` and `coef_we` in the same cycle: the write is performed.
- Reset: all registers cleared, including coefficients. `fir_valid` = 0, `fir_d` = 0, `sat_flag` = 0. Reset asserted mid-stream discards all in-flight results; no `fir_valid` pulse follows the release of reset until warm-up completes again.
- Between valid results, `fir_d` and `sat_flag` hold their last values.

## Timing
- Sample accepted on edge k produces `fir_d`/`fir_valid` registered on edge k+LAT. LAT = 2 + log2(TAPS/2), which is 6 by default.
- Throughput: one sample per cycle; any gap pattern on `data_valid` is allowed.
- No back-pressure; the consumer must accept every `fir_valid` pulse.
- `fir_valid` is high for exactly one cycle per qualifying sample; back-to-back samples give back-to-back pulses.
- `clr` on edge k suppresses every result that would otherwise appear on edges k+1..k+LAT.

## Configuration
- `FIR_SAT_EN` defined: after rounding, values above 2^(DATA_W−1)−1 clip to that maximum and values below −2^(DATA_W−1) clip to that minimum. `sat_flag` is set with the clipped result.
- `FIR_SAT_EN` undefined: the rounded value is truncated to its low DATA_W bits (two's-complement wrap). `sat_flag` is tied to 0.

## Structure
- Package `fir_sym_pkg`:
  - `clog2` function.
  - Default DATA_W/COEF_W/TAPS/FRAC_W.
  - Derived constants HALF = TAPS/2, LVL = log2(HALF), ACC_W, LAT.
- Sub-module `fir_add_tree`: pipelined, parametrised adder tree with an input-width parameter and an input-count parameter (a power of 2). It carries the valid bit alongside the data.

## Test plan
All scenarios use default parameters.
1. Impulse: c[0]=16384, others 0. Feed 31 zeros, then one sample of 1000, then zeros.
   - `fir_d`=500 for sample index 31, and again for index 62; 0 otherwise.
   - No `fir_valid` for samples 0..30.
2. Rounding: c[0]=1, others 0. After warm-up, feed `data`=16384 → `fir_d`=1; feed `data`=16383 → `fir_d`=0.
3. Saturation: all c[i]=32767, constant `data`=32767.
   - With `FIR_SAT_EN`: `fir_d`=32767 and `sat_flag`=1.
   - With `data`=−32768: `fir_d`=−32768 and `sat_flag`=1.
   - Without `FIR_SAT_EN`: `fir_d` equals the wrapped low 16 bits and `sat_flag`=0.
4. Gaps: same stimulus as scenario 1, with `data_valid` toggled 1/0 every cycle. The values equal those of scenario 1, and each lands LAT cycles after its accepting edge.
5. `clr` mid-stream after 40 samples:
   - No `fir_valid` for the next LAT cycles, nor for the next 31 samples.
   - Coefficients remain in effect: the scenario-1 impulse response reappears.
6. `rst` pulse asserted mid-stream:
   - All outputs go to 0 immediately (asynchronously).
   - With coefficients now 0 and warm-up complete, `fir_d` = 0 for every result.
